// File: rtl/data_write_port_pkg.sv
// rtl/data_write_port_pkg.sv - shared types and constants for the posted-write store port
package data_write_port_pkg;

    typedef logic [31:0] regval_t;

    localparam int WriteBufferDepth = 4;

    typedef struct packed {
        logic [29:0] word_address;
        regval_t     data;
    } wb_entry_t;

    typedef enum logic {
        BUS_IDLE  = 1'b0,
        BUS_ISSUE = 1'b1
    } bus_state_e;

endpackage

// File: rtl/data_write_port_if.sv
// rtl/data_write_port_if.sv - store handshake and data bus signals of the write port
interface data_write_port_if;
    import data_write_port_pkg::*;

    logic        address_enable;
    regval_t     address;
    regval_t     data;
    logic        data_valid;

    logic        bus_write;
    logic [29:0] bus_address;
    regval_t     bus_writedata;
    logic        bus_waitrequest;

    // master: write stage plus data bus; slave: the write port itself
    modport master (
        output address_enable, address, data, bus_waitrequest,
        input  data_valid, bus_write, bus_address, bus_writedata
    );

    modport slave (
        input  address_enable, address, data, bus_waitrequest,
        output data_valid, bus_write, bus_address, bus_writedata
    );
endinterface

// File: rtl/data_write_port_fifo.sv
// rtl/data_write_port_fifo.sv - circular posted-write buffer with per-entry valid bits for probing
module write_buffer_fifo
    import data_write_port_pkg::*;
#(
    parameter int Depth = WriteBufferDepth
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output wb_entry_t                  entries [Depth],
    output logic [Depth-1:0]           valid,
    output logic [$clog2(Depth)-1:0]   rd_idx,
    output logic [$clog2(Depth):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    wb_entry_t        mem_q [Depth];
    wb_entry_t        mem_d [Depth];
    logic [Depth-1:0] valid_q, valid_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        valid_d  = valid_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]]   = push_entry;
            valid_d[wr_ptr_q[AW-1:0]] = 1'b1;
            wr_ptr_d                  = wr_ptr_q + PtrOne;
        end
        // push and pop never share a slot: push needs !full, pop needs !empty
        if (pop) begin
            valid_d[rd_ptr_q[AW-1:0]] = 1'b0;
            rd_ptr_d                  = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign entries = mem_q;
    assign valid   = valid_q;
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/data_write_port.sv
// rtl/data_write_port.sv - store responder: accepts stores into a posted-write buffer and drains them to the bus
module data_write_port
    import data_write_port_pkg::*;
#(
    parameter int Depth      = WriteBufferDepth,
    parameter int CountWidth = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    data_write_port_if.slave      port_if,
    input  regval_t               probe_address,
    output logic                  probe_hit,
    output regval_t               probe_data,
    output logic                  is_empty,
    output logic                  misaligned,
    output logic [CountWidth-1:0] store_count
);
    localparam int AW = $clog2(Depth);

    bus_state_e            state_q, state_d;
    logic                  misaligned_q, misaligned_d;
    logic [CountWidth-1:0] store_count_q, store_count_d;

    logic             aligned;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        entries [Depth];
    logic [Depth-1:0] valid;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      count;
    logic             unused_probe_bits;

    assign aligned    = (port_if.address[1:0] == 2'b00);
    // misaligned stores are acknowledged even when full so the write stage never deadlocks on them
    assign port_if.data_valid = port_if.address_enable && (!aligned || !full);
    assign push       = port_if.address_enable && aligned && !full;
    assign pop        = port_if.bus_write && !port_if.bus_waitrequest;
    assign push_entry = '{word_address: port_if.address[31:2], data: port_if.data};

    write_buffer_fifo #(.Depth(Depth)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .entries    (entries),
        .valid      (valid),
        .rd_idx     (rd_idx),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_d       = state_q;
        misaligned_d  = misaligned_q || (port_if.address_enable && !aligned);
        store_count_d = store_count_q + CountWidth'(pop);
        case (state_q)
            BUS_IDLE:  if (push) state_d = BUS_ISSUE;
            BUS_ISSUE: if (pop && (count == {{AW{1'b0}}, 1'b1}) && !push) state_d = BUS_IDLE;
            default:   state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BUS_IDLE;
            misaligned_q  <= 1'b0;
            store_count_q <= '0;
        end else begin
            state_q       <= state_d;
            misaligned_q  <= misaligned_d;
            store_count_q <= store_count_d;
        end
    end

    assign port_if.bus_write     = (state_q == BUS_ISSUE);
    assign port_if.bus_address   = head.word_address;
    assign port_if.bus_writedata = head.data;

    // walk oldest to youngest from the read index so the last match found is the youngest store
    always_comb begin
        logic [AW-1:0] idx;
        idx        = '0;
        probe_hit  = 1'b0;
        probe_data = '0;
        for (int k = 0; k < Depth; k++) begin
            idx = rd_idx + AW'(k);
            if (valid[idx] && (entries[idx].word_address == probe_address[31:2])) begin
                probe_hit  = 1'b1;
                probe_data = entries[idx].data;
            end
        end
    end

    assign unused_probe_bits = ^probe_address[1:0];
    assign is_empty          = empty;
    assign misaligned        = misaligned_q;
    assign store_count       = store_count_q;

endmodule

// File: tb/tb_data_write_port.sv
// tb/tb_data_write_port.sv - directed self-checking bench for data_write_port
module tb_data_write_port;
    import data_write_port_pkg::*;

    logic        clock;
    logic        reset_n;
    regval_t     probe_address;
    logic        probe_hit;
    regval_t     probe_data;
    logic        is_empty;
    logic        misaligned;
    logic [15:0] store_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [29:0] mon_addr [$];
    regval_t     mon_data [$];

    data_write_port_if bus ();

    data_write_port #(.Depth(4), .CountWidth(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .port_if       (bus),
        .probe_address (probe_address),
        .probe_hit     (probe_hit),
        .probe_data    (probe_data),
        .is_empty      (is_empty),
        .misaligned    (misaligned),
        .store_count   (store_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n && bus.bus_write && !bus.bus_waitrequest) begin
            mon_addr.push_back(bus.bus_address);
            mon_data.push_back(bus.bus_writedata);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.address_enable  = 1'b0;
        bus.address         = '0;
        bus.data            = '0;
        bus.bus_waitrequest = 1'b0;
        probe_address       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mon_addr.delete();
        mon_data.delete();
        tick();
    endtask

    task automatic drive_store(input regval_t a, input regval_t d);
        bus.address_enable = 1'b1;
        bus.address        = a;
        bus.data           = d;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", bus.data_valid); end n_checks++;
        if (bus.bus_write !== 1'b0) begin n_fail++; $display("FAIL reset_bus_write got %b want 0", bus.bus_write); end n_checks++;
        if (probe_hit !== 1'b0 || probe_data !== 32'h0) begin n_fail++; $display("FAIL reset_probe got %b/%h want 0/0", probe_hit, probe_data); end n_checks++;
        if (is_empty !== 1'b1) begin n_fail++; $display("FAIL reset_is_empty got %b want 1", is_empty); end n_checks++;
        if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got %b want 0", misaligned); end n_checks++;
        if (store_count !== 16'd0) begin n_fail++; $display("FAIL reset_store_count got %0d want 0", store_count); end n_checks++;
    endtask

    task automatic test_single(input logic [15:0] base_count);
        drive_store(32'h100, 32'hDEADBEEF);
        #1;
        if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL single_data_valid got %b want 1", bus.data_valid); end n_checks++;
        if (bus.bus_write !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", bus.bus_write); end n_checks++;
        tick();
        bus.address_enable = 1'b0;
        #1;
        if (bus.bus_write !== 1'b1 || bus.bus_address !== 30'h40 || bus.bus_writedata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_bus got %b/%h/%h want 1/40/deadbeef", bus.bus_write, bus.bus_address, bus.bus_writedata);
        end n_checks++;
        if (is_empty !== 1'b0) begin n_fail++; $display("FAIL single_not_empty got %b want 0", is_empty); end n_checks++;
        tick();
        if (store_count !== base_count + 16'd1) begin n_fail++; $display("FAIL single_store_count got %0d want %0d", store_count, base_count + 16'd1); end n_checks++;
        if (is_empty !== 1'b1 || bus.bus_write !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b/%b want 1/0", is_empty, bus.bus_write); end n_checks++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.bus_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
            #1;
            if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_accept_%0d got %b want 1", i, bus.data_valid); end n_checks++;
            tick();
        end
        drive_store(32'h1010, 32'hA4);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold_%0d got %b want 0", c, bus.data_valid); end n_checks++;
            if (bus.bus_address !== 30'h400) begin n_fail++; $display("FAIL bp_head_stable_%0d got %h want 400", c, bus.bus_address); end n_checks++;
            tick();
        end
        bus.bus_waitrequest = 1'b0;
        #1;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_pushthrough got %b want 0", bus.data_valid); end n_checks++;
        tick();
        #1;
        if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume got %b want 1", bus.data_valid); end n_checks++;
        tick();
        bus.address_enable = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        if (mon_addr.size() !== 5) begin
            n_fail++; $display("FAIL bp_count_on_bus got %0d want 5", mon_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (mon_addr[i] !== 30'h400 + 30'(i) || mon_data[i] !== 32'hA0 + 32'(i)) begin
                    n_fail++; $display("FAIL bp_order_%0d got %h/%h want %h/%h", i, mon_addr[i], mon_data[i], 30'h400 + 30'(i), 32'hA0 + 32'(i));
                end
            end
        end n_checks++;
        if (store_count !== 16'd5 || is_empty !== 1'b1) begin n_fail++; $display("FAIL bp_final got %0d/%b want 5/1", store_count, is_empty); end n_checks++;
    endtask

    task automatic test_probe();
        do_reset();
        bus.bus_waitrequest = 1'b1;
        drive_store(32'h200, 32'h11);
        tick();
        drive_store(32'h200, 32'h22);
        tick();
        drive_store(32'h300, 32'h33);
        probe_address = 32'h300;
        #1;
        if (probe_hit !== 1'b0) begin n_fail++; $display("FAIL probe_incoming_hidden got %b want 0", probe_hit); end n_checks++;
        bus.address_enable = 1'b0;
        probe_address = 32'h203;
        #1;
        if (probe_hit !== 1'b1 || probe_data !== 32'h22) begin n_fail++; $display("FAIL probe_youngest got %b/%h want 1/22", probe_hit, probe_data); end n_checks++;
        probe_address = 32'h204;
        #1;
        if (probe_hit !== 1'b0 || probe_data !== 32'h0) begin n_fail++; $display("FAIL probe_miss got %b/%h want 0/0", probe_hit, probe_data); end n_checks++;
        bus.bus_waitrequest = 1'b0;
        probe_address = 32'h200;
        tick();
        if (probe_hit !== 1'b1 || probe_data !== 32'h22) begin n_fail++; $display("FAIL probe_after_pop got %b/%h want 1/22", probe_hit, probe_data); end n_checks++;
        tick();
        if (probe_hit !== 1'b0) begin n_fail++; $display("FAIL probe_after_drain got %b want 0", probe_hit); end n_checks++;
    endtask

    task automatic test_misaligned();
        do_reset();
        drive_store(32'h102, 32'h5);
        #1;
        if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL mis_data_valid got %b want 1", bus.data_valid); end n_checks++;
        tick();
        bus.address_enable = 1'b0;
        #1;
        if (misaligned !== 1'b1 || bus.bus_write !== 1'b0 || is_empty !== 1'b1) begin
            n_fail++; $display("FAIL mis_dropped got %b/%b/%b want 1/0/1", misaligned, bus.bus_write, is_empty);
        end n_checks++;
        bus.bus_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h500 + 32'(4 * i), 32'(i));
            tick();
        end
        drive_store(32'h511, 32'h77);
        #1;
        if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL mis_full_ack got %b want 1", bus.data_valid); end n_checks++;
        tick();
        bus.address_enable = 1'b0;
        bus.bus_waitrequest = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        if (misaligned !== 1'b1 || mon_addr.size() !== 4 || store_count !== 16'd4) begin
            n_fail++; $display("FAIL mis_sticky got %b/%0d/%0d want 1/4/4", misaligned, mon_addr.size(), store_count);
        end n_checks++;
    endtask

    task automatic test_push_pop_same_edge();
        do_reset();
        bus.bus_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h10 + 32'(4 * i), 32'(i + 1));
            tick();
        end
        drive_store(32'h1C, 32'h4);
        bus.bus_waitrequest = 1'b0;
        #1;
        if (bus.data_valid !== 1'b1 || bus.bus_address !== 30'h4) begin n_fail++; $display("FAIL pp_setup got %b/%h want 1/4", bus.data_valid, bus.bus_address); end n_checks++;
        tick();
        bus.bus_waitrequest = 1'b1;
        drive_store(32'h20, 32'h5);
        #1;
        if (bus.data_valid !== 1'b1 || bus.bus_address !== 30'h5) begin n_fail++; $display("FAIL pp_occupancy3 got %b/%h want 1/5", bus.data_valid, bus.bus_address); end n_checks++;
        tick();
        bus.address_enable = 1'b0;
        probe_address = 32'h10;
        #1;
        if (probe_hit !== 1'b0) begin n_fail++; $display("FAIL pp_popped_gone got %b want 0", probe_hit); end n_checks++;
        drive_store(32'h24, 32'h6);
        #1;
        if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL pp_full got %b want 0", bus.data_valid); end n_checks++;
        bus.address_enable = 1'b0;
        bus.bus_waitrequest = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        if (mon_addr.size() !== 5) begin
            n_fail++; $display("FAIL pp_bus_count got %0d want 5", mon_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (mon_addr[i] !== 30'h4 + 30'(i) || mon_data[i] !== 32'(i + 1)) begin
                    n_fail++; $display("FAIL pp_order_%0d got %h/%h want %h/%h", i, mon_addr[i], mon_data[i], 30'h4 + 30'(i), 32'(i + 1));
                end
            end
        end n_checks++;
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        drive_store(32'h40, 32'h99);
        tick();
        bus.address_enable = 1'b0;
        tick();
        bus.bus_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h600 + 32'(4 * i), 32'hC0 + 32'(i));
            tick();
        end
        bus.address_enable = 1'b0;
        #1;
        if (bus.bus_write !== 1'b1 || store_count !== 16'd1) begin n_fail++; $display("FAIL rm_pre got %b/%0d want 1/1", bus.bus_write, store_count); end n_checks++;
        reset_n = 1'b0;
        #1;
        if (bus.bus_write !== 1'b0 || is_empty !== 1'b1 || store_count !== 16'd0) begin
            n_fail++; $display("FAIL rm_async got %b/%b/%0d want 0/1/0", bus.bus_write, is_empty, store_count);
        end n_checks++;
        tick();
        reset_n = 1'b1;
        bus.bus_waitrequest = 1'b0;
        tick();
        if (bus.bus_write !== 1'b0) begin n_fail++; $display("FAIL rm_no_retry got %b want 0", bus.bus_write); end n_checks++;
        test_single(16'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single(16'd0);
        test_backpressure();
        test_probe();
        test_misaligned();
        test_push_pop_same_edge();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
